// File: rtl/tmr_pkg.sv
// tmr_pkg: FSM state encoding and parameter defaults for the TMR resync controller
package tmr_pkg;
  typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, LOCKOUT = 2'd2} state_t;
  localparam int DEF_N_CORES     = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_MAX_RESYNC  = 3;
endpackage

// File: rtl/tmr_reset_sync.sv
// tmr_reset_sync: async-assert, sync-deassert reset synchronizer
module tmr_reset_sync
  import tmr_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n_in,
  output logic rst_sync_n
);
  logic [SYNC_STAGES-1:0] sr;
  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) sr <= '0;
    else sr <= {sr[SYNC_STAGES-2:0], 1'b1};
  assign rst_sync_n = sr[SYNC_STAGES-1];
endmodule

// File: rtl/tmr_resync_controller.sv
// tmr_resync_controller: holds lockstep cores in reset, releases them together,
// and re-synchronizes them on fault or request until the resync budget runs out
module tmr_resync_controller
  import tmr_pkg::*;
#(
  parameter int N_CORES     = DEF_N_CORES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_RESYNC  = DEF_MAX_RESYNC
) (
  input  logic               clk,
  input  logic               rst_n_in,
  input  logic [N_CORES-1:0] fault_in,
  input  logic               resync_req,
  output logic [N_CORES-1:0] rst_n_core,
  output logic               sync_active,
  output logic [CNT_W-1:0]   sync_counter,
  output logic [3:0]         resync_count,
  output logic [N_CORES-1:0] fault_mask,
  output logic               lockout,
  output logic [1:0]         state
);
  logic               rst_sync_n;
  state_t             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [3:0]         rc_d;
  logic [N_CORES-1:0] mask_d;
  logic               req_q;
  logic               trig;
  tmr_reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n_in   (rst_n_in),
    .rst_sync_n (rst_sync_n)
  );
  always_ff @(posedge clk or negedge rst_sync_n)
    if (!rst_sync_n) begin
      state_q      <= HOLD;
      hold_q       <= '0;
      sync_counter <= '0;
      resync_count <= '0;
      fault_mask   <= '0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      sync_counter <= cnt_d;
      resync_count <= rc_d;
      fault_mask   <= mask_d;
      req_q        <= resync_req;
    end
  // a fault and a request edge on the same cycle form a single event
  assign trig = (|fault_in) | (resync_req & ~req_q);
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = sync_counter;
    rc_d    = resync_count;
    mask_d  = fault_mask;
    case (state_q)
      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == 8'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          hold_d  = '0;
        end
      end
      RUN:
        if (trig) begin
          mask_d  = fault_mask | fault_in;
          cnt_d   = '0;
          hold_d  = '0;
          state_d = resync_count < 4'(MAX_RESYNC) ? HOLD : LOCKOUT;
          rc_d    = resync_count < 4'(MAX_RESYNC) ? resync_count + 1'b1 : resync_count;
        end else cnt_d = &sync_counter ? sync_counter : sync_counter + 1'b1;
      LOCKOUT: state_d = LOCKOUT;
      default: state_d = HOLD;
    endcase
  end
  // core resets are released exactly while the registered state is RUN
  assign rst_n_core  = {N_CORES{state_q == RUN}};
  assign sync_active = state_q == RUN;
  assign lockout     = state_q == LOCKOUT;
  assign state       = state_q;
endmodule

// File: doc/tmr_resync_controller.md
TMR_RESYNC_CONTROLLER -- requirements
Module: tmr_resync_controller

Interface
REQ-001 Parameter N_CORES, default 3, number of lockstep cores (range 2..8).
REQ-002 Parameter SYNC_STAGES, default 2, reset-synchronizer depth (range 2..4).
REQ-003 Parameter HOLD_CYCLES, default 16, cycles cores are held in reset before each release (range 1..255).
REQ-004 Parameter CNT_W, default 8, width of sync_counter.
REQ-005 Parameter MAX_RESYNC, default 3, resync events allowed before lockout (range 0..15).
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-008 fault_in  input  N_CORES  per-core voter-disagreement flag, level, synchronous to clk.
REQ-009 resync_req  input  1  software resync request, synchronous to clk, rising edge significant.
REQ-010 rst_n_core  output  N_CORES  per-core active-low reset, registered, all bits always identical.
REQ-011 sync_active  output  1  high while in RUN.
REQ-012 sync_counter  output  CNT_W  cycles since last release, saturating.
REQ-013 resync_count  output  4  resync events since rst_n_in deassertion, saturating at MAX_RESYNC.
REQ-014 fault_mask  output  N_CORES  sticky OR of fault_in values that triggered a resync.
REQ-015 lockout  output  1  high when resync budget exhausted; cores permanently held.
REQ-016 state  output  2  current FSM state encoding (debug).

Function
REQ-017 Internal synchronized reset rst_sync_n SHALL assert asynchronously with rst_n_in and deassert on the SYNC_STAGES-th rising clk edge after rst_n_in rises.
REQ-018 FSM states SHALL be HOLD(0), RUN(1), LOCKOUT(2); rst_sync_n low forces HOLD with hold counter 0.
REQ-019 HOLD: hold counter increments each edge; on the edge where counter == HOLD_CYCLES-1, state -> RUN and all rst_n_core bits go 1 on that same edge.
REQ-020 Release latency SHALL be exactly SYNC_STAGES + HOLD_CYCLES edges from rst_n_in rising.
REQ-021 RUN: sync_active=1; sync_counter increments per edge, saturates at all-ones.
REQ-022 Trigger = (|fault_in) OR (resync_req rising edge, detected against a registered copy), evaluated only in RUN.
REQ-023 Trigger in RUN with resync_count < MAX_RESYNC: next edge state -> HOLD, rst_n_core all 0, sync_active 0, sync_counter 0, hold counter 0, resync_count +1, fault_mask |= fault_in.
REQ-024 Trigger in RUN with resync_count == MAX_RESYNC: next edge state -> LOCKOUT, rst_n_core all 0, lockout 1, fault_mask |= fault_in; resync_count unchanged.
REQ-025 Simultaneous fault and resync_req edge SHALL count as one event.
REQ-026 fault_in and resync_req SHALL be ignored in HOLD and LOCKOUT; a fault persisting through HOLD retriggers on the first RUN edge.
REQ-027 LOCKOUT SHALL be exited only by rst_n_in assertion.
REQ-028 MAX_RESYNC = 0 SHALL send the first trigger directly to LOCKOUT.

Reset
REQ-029 While rst_sync_n low: rst_n_core all 0, sync_active 0, sync_counter 0, lockout 0, state HOLD, hold counter 0.
REQ-030 resync_count and fault_mask SHALL clear only on rst_n_in (via rst_sync_n), never on internal resync.
REQ-031 rst_n_in assertion mid-HOLD, mid-RUN or in LOCKOUT SHALL drive all outputs to reset values asynchronously.

Structure
REQ-032 Package tmr_pkg SHALL hold the FSM state encoding constants and parameter defaults.
REQ-033 Sub-module tmr_reset_sync SHALL implement the SYNC_STAGES synchronizer; the FSM and counters stay in the top.

Verification
REQ-034 Defaults; release rst_n_in -> rst_n_core = 3'b111 and sync_active=1 exactly 18 edges later; sync_counter reaches 8'hFF and holds.
REQ-035 RUN, pulse fault_in=3'b010 one cycle -> next edge rst_n_core=3'b000, resync_count=1, fault_mask=3'b010; release again 16 edges later.
REQ-036 Hold fault_in=3'b001 constant -> three resyncs (resync_count=3), fourth trigger -> lockout=1, state=2, rst_n_core=0 indefinitely.
REQ-037 Hold resync_req high for 50 cycles in RUN -> exactly one resync; fault_in=3'b100 on the same edge as a rising resync_req -> resync_count +1 only.
REQ-038 Assert rst_n_in during LOCKOUT and mid-HOLD -> all outputs at reset values without a clock; resync_count=0, fault_mask=0.
REQ-039 N_CORES=5, MAX_RESYNC=0, HOLD_CYCLES=1 -> release 3 edges after rst_n_in; first fault -> immediate LOCKOUT.
